// File: rtl/psalm_tx_sequencer_if.sv
// psalm_tx_sequencer_if: BRAM read port plus UART write/busy handshake.
// master = sequencer side, slave = memory/UART side.
interface psalm_tx_sequencer_if #(
    parameter int W  = 11,
    parameter int DW = 8
);
    logic [W-1:0]  o_mem_addr;
    logic [DW-1:0] i_mem_data;
    logic          o_wr;
    logic [DW-1:0] o_data;
    logic          i_busy;

    modport master (
        output o_mem_addr, o_wr, o_data,
        input  i_mem_data, i_busy
    );

    modport slave (
        input  o_mem_addr, o_wr, o_data,
        output i_mem_data, i_busy
    );
endinterface

// File: rtl/psalm_tx_sequencer.sv
// psalm_tx_sequencer: streams a zero-terminated BRAM message to a UART.
// Define PSALM_TX_CRLF_EN to send every LF byte as a CR, LF pair.
module psalm_tx_sequencer #(
    parameter int          W            = 11,
    parameter int          DW           = 8,
    parameter int          MSG_LEN      = 2048,
    parameter logic [23:0] PAUSE_CYCLES = 24'd1000000,
    parameter int          AUTO_REPEAT  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    psalm_tx_sequencer_if.master  bus,
    output logic                  o_active
);

`ifdef PSALM_TX_CRLF_EN
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LOAD, S_SEND, S_PAUSE, S_LF
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LOAD, S_SEND, S_PAUSE
    } state_t;
`endif

    localparam logic [W-1:0] LAST = W'(MSG_LEN - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  addr_q, addr_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] data_q, data_d;
    logic [23:0]   cnt_q, cnt_d;
`ifdef PSALM_TX_CRLF_EN
    logic          crlf_q, crlf_d;
`endif

    logic accept;
    logic last;
    logic pause_done;
    logic repeat_en;

    assign accept     = wr_q && !bus.i_busy;
    assign last       = (addr_q == LAST);
    assign pause_done = (PAUSE_CYCLES == 24'd0) ||
                        (cnt_q == PAUSE_CYCLES - 24'd1);
    assign repeat_en  = (AUTO_REPEAT != 0);

    assign bus.o_mem_addr = addr_q;
    assign bus.o_wr       = wr_q;
    assign bus.o_data     = data_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
`ifdef PSALM_TX_CRLF_EN
            crlf_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
`ifdef PSALM_TX_CRLF_EN
            crlf_q  <= crlf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start || repeat_en) state_d = S_READ;
            end
            S_READ: state_d = S_LOAD;
            S_LOAD: begin
                if (bus.i_mem_data == '0) state_d = S_PAUSE;
                else                      state_d = S_SEND;
            end
            S_SEND: begin
`ifdef PSALM_TX_CRLF_EN
                if (accept && crlf_q)
                    state_d = S_LF;
                else if (accept)
                    state_d = last ? S_PAUSE : S_READ;
`else
                if (accept) state_d = last ? S_PAUSE : S_READ;
`endif
            end
`ifdef PSALM_TX_CRLF_EN
            S_LF: begin
                if (accept) state_d = last ? S_PAUSE : S_READ;
            end
`endif
            S_PAUSE: begin
                if (pause_done) state_d = repeat_en ? S_READ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        wr_d     = wr_q;
        data_d   = data_q;
        cnt_d    = '0;
        o_active = (state_q != S_IDLE);
`ifdef PSALM_TX_CRLF_EN
        crlf_d   = crlf_q;
`endif
        unique case (state_q)
            S_IDLE: addr_d = '0;
            S_LOAD: begin
                if (bus.i_mem_data != '0) begin
                    wr_d   = 1'b1;
                    data_d = bus.i_mem_data;
`ifdef PSALM_TX_CRLF_EN
                    if (bus.i_mem_data == DW'(8'h0A)) begin
                        data_d = DW'(8'h0D);
                        crlf_d = 1'b1;
                    end
`endif
                end
            end
            S_SEND: begin
                if (accept) begin
                    wr_d = 1'b0;
`ifdef PSALM_TX_CRLF_EN
                    // CR accepted: keep the address, LF still owed
                    if (crlf_q)     crlf_d = 1'b0;
                    else if (!last) addr_d = addr_q + 1'b1;
`else
                    if (!last) addr_d = addr_q + 1'b1;
`endif
                end
            end
`ifdef PSALM_TX_CRLF_EN
            S_LF: begin
                if (!wr_q) begin
                    wr_d   = 1'b1;
                    data_d = DW'(8'h0A);
                end else if (accept) begin
                    wr_d = 1'b0;
                    if (!last) addr_d = addr_q + 1'b1;
                end
            end
`endif
            S_PAUSE: begin
                addr_d = '0;
                cnt_d  = pause_done ? 24'd0 : cnt_q + 24'd1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_psalm_tx_sequencer.sv
// tb_psalm_tx_sequencer: scoreboard bench, one-shot and auto-repeat DUTs.
// Expected bytes, addresses and spacing come from a message-level model.
module tb_psalm_tx_sequencer;

    localparam int          WA  = 3;
    localparam int          MLA = 8;
    localparam logic [23:0] PA  = 24'd3;
    localparam int          WB  = 4;
    localparam int          MLB = 2;
    localparam logic [23:0] PB  = 24'd5;

    typedef struct {
        logic [7:0] d;
        int         addr;
        int         gap;
    } exp_t;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic start_a = 1'b0;
    logic act_a;
    logic act_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int busy_mode = 0;

    psalm_tx_sequencer_if #(.W(WA), .DW(8)) ifa ();
    psalm_tx_sequencer_if #(.W(WB), .DW(8)) ifb ();

    logic [7:0] mem_a [0:MLA-1];
    logic [7:0] mem_b [0:(1<<WB)-1];

    exp_t q_a[$];
    exp_t e_a;
    int   last_acc_a = 0;
    logic pw_a = 1'b0;
    logic pb_a = 1'b0;
    logic [7:0] pd_a = 8'h00;

    int   last_acc_b = 0;
    int   idx_b = 0;
    int   gap_b = 4;
    logic pw_b = 1'b0;

    psalm_tx_sequencer #(
        .W(WA), .DW(8), .MSG_LEN(MLA),
        .PAUSE_CYCLES(PA), .AUTO_REPEAT(0)
    ) dut_a (
        .i_clk(clk), .i_reset(rst), .i_start(start_a),
        .bus(ifa.master), .o_active(act_a)
    );

    psalm_tx_sequencer #(
        .W(WB), .DW(8), .MSG_LEN(MLB),
        .PAUSE_CYCLES(PB), .AUTO_REPEAT(1)
    ) dut_b (
        .i_clk(clk), .i_reset(rst), .i_start(1'b0),
        .bus(ifb.master), .o_active(act_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM models with one-cycle registered read
    always @(posedge clk) begin
        ifa.i_mem_data <= mem_a[ifa.o_mem_addr];
        ifb.i_mem_data <= mem_b[ifb.o_mem_addr];
    end

    initial begin
        ifa.i_busy = 1'b0;
        ifb.i_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (busy_mode)
                0:       ifa.i_busy = 1'b0;
                1:       ifa.i_busy = 1'b1;
                default: ifa.i_busy = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Message-level model: bytes up to the terminator or MSG_LEN
    task automatic push_model();
        logic [7:0] b;
        for (int a = 0; a < MLA; a++) begin
            b = mem_a[a];
            if (b == 8'h00) break;
`ifdef PSALM_TX_CRLF_EN
            if (b == 8'h0A) begin
                q_a.push_back('{d: 8'h0D, addr: a, gap: 3});
                q_a.push_back('{d: 8'h0A, addr: a, gap: 2});
                continue;
            end
`endif
            q_a.push_back('{d: b, addr: a, gap: 3});
        end
    endtask

    task automatic rand_mem();
        int r;
        for (int i = 0; i < MLA; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0)      mem_a[i] = 8'h00;
            else if (r == 1) mem_a[i] = 8'h0A;
            else             mem_a[i] = 8'($urandom_range(1, 255));
        end
    endtask

    task automatic start_msg();
        push_model();
        @(posedge clk);
        #1;
        start_a = 1'b1;
        last_acc_a = cyc;
        @(posedge clk);
        #1;
        start_a = 1'b0;
    endtask

    task automatic wait_wr(input string tag);
        int n;
        n = 0;
        while (!ifa.o_wr && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wr_seen"}, 32'(ifa.o_wr), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((q_a.size() != 0 || act_a) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(q_a.size() == 0 && !act_a), 32'd1);
        chk({tag, "_idle_addr"}, 32'(ifa.o_mem_addr), 32'd0);
        chk({tag, "_idle_wr"}, 32'(ifa.o_wr), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            pw_a = 1'b0;
            pb_a = 1'b0;
        end else begin
            if (ifa.o_wr && !pw_a) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_wr", 32'd1, 32'd0);
                end else begin
                    chk("a_gap", 32'(cyc - last_acc_a), 32'(q_a[0].gap));
                    chk("a_addr", 32'(ifa.o_mem_addr), 32'(q_a[0].addr));
                end
            end
            if (ifa.o_wr && pw_a && pb_a)
                chk("a_hold_data", 32'(ifa.o_data), 32'(pd_a));
            if (ifa.o_wr && !ifa.i_busy) begin
                if (q_a.size() != 0) begin
                    e_a = q_a.pop_front();
                    chk("a_data", 32'(ifa.o_data), 32'(e_a.d));
                end
                last_acc_a = cyc;
            end
            pw_a = ifa.o_wr;
            pb_a = ifa.i_busy;
            pd_a = ifa.o_data;
        end
    end

    // Auto-repeat stream: b0, b1, pause, b0, b1, ...
    always @(negedge clk) begin
        if (rst) begin
            pw_b = 1'b0;
            idx_b = 0;
            gap_b = 4;
            last_acc_b = cyc;
        end else begin
            if (ifb.o_wr && !pw_b) begin
                chk("b_gap", 32'(cyc - last_acc_b), 32'(gap_b));
                chk("b_addr", 32'(ifb.o_mem_addr), 32'(idx_b));
            end
            if (ifb.o_wr && !ifb.i_busy) begin
                chk("b_data", 32'(ifb.o_data), 32'(mem_b[idx_b]));
                last_acc_b = cyc;
                if (idx_b == 0) begin
                    idx_b = 1;
                    gap_b = 3;
                end else begin
                    idx_b = 0;
                    gap_b = 3 + int'(PB);
                end
            end
            pw_b = ifb.o_wr;
        end
    end

    initial begin
        for (int i = 0; i < MLA; i++) mem_a[i] = 8'h00;
        for (int i = 0; i < (1 << WB); i++) mem_b[i] = 8'h00;
        mem_b[0] = 8'h55;
        mem_b[1] = 8'hAA;

        repeat (4) @(posedge clk);
        #1;
        chk("rst_addr", 32'(ifa.o_mem_addr), 32'd0);
        chk("rst_wr", 32'(ifa.o_wr), 32'd0);
        chk("rst_data", 32'(ifa.o_data), 32'd0);
        chk("rst_active", 32'(act_a), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_start", 32'(act_a), 32'd0);

        for (int i = 0; i < MLA; i++) mem_a[i] = 8'(8'h41 + i);
        busy_mode = 0;
        start_msg();
        wait_done("basic");

        busy_mode = 1;
        start_msg();
        wait_wr("bp");
        repeat (10) @(negedge clk);
        busy_mode = 0;
        wait_done("backpressure");

        mem_a[0] = 8'h48;
        mem_a[1] = 8'h49;
        mem_a[2] = 8'h00;
        mem_a[3] = 8'h5A;
        start_msg();
        wait_done("terminator");

        for (int i = 0; i < MLA; i++) mem_a[i] = 8'(8'h61 + i);
        busy_mode = 1;
        start_msg();
        wait_wr("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_wr", 32'(ifa.o_wr), 32'd0);
        chk("midrst_data", 32'(ifa.o_data), 32'd0);
        chk("midrst_addr", 32'(ifa.o_mem_addr), 32'd0);
        chk("midrst_active", 32'(act_a), 32'd0);
        rst = 1'b0;
        q_a.delete();
        busy_mode = 2;
        start_msg();
        wait_done("after_rst");

        mem_a[0] = 8'h41;
        mem_a[1] = 8'h0A;
        mem_a[2] = 8'h42;
        mem_a[3] = 8'h00;
        busy_mode = 0;
        start_msg();
        wait_done("crlf");

        for (int t = 0; t < 12; t++) begin
            rand_mem();
            busy_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            start_msg();
            wait_done("rand");
        end

        repeat (20) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
